hps_cmd_bridge: RTL and testbench
=================================

// Module: hps_cmd_bridge
// PURPOSE
//  Sits between the HPS terminal and the GPIP register bus. Buffers 64-bit write instructions
//  in a FIFO and replays each one as a register-bus write. When idle, scans a register window
//  and returns each value as a read instruction (rd_valid/rd) for the terminal's readback array.
// PARAMETERS
//  DEPTH         16        command FIFO entries, power of 2, >= 4
//  AW            4         log2(DEPTH)
//  SCAN_BASE     16'h0000  first register-bus address scanned
//  SCAN_LEN      64        number of scanned registers, 1..700
//  RD_ADDR_BASE  300       terminal readback index for scan entry 0
// PORTS
//  s_clk            in   1   clock
//  s_reset          in   1   asynchronous, active-high reset
//  wr               in   1   command strobe; may stay high >1 cycle, one push per rising edge
//  wr_instruction   in   64  {data[63:32], rsvd[31:16], addr[15:0]}
//  wr_busy          out  1   FIFO almost full; terminal must not raise wr
//  rd_valid         out  1   response held for terminal
//  rd_instruction   out  64  {rdata[63:32], 16'h0, dest_index[15:0]}
//  rd               in   1   response consume strobe; may stay high >1 cycle, one pop per rising edge
//  scan_en          in   1   enables the background scan
//  reg_addr         out  16  register-bus address
//  reg_wdata        out  32  register-bus write data
//  reg_write        out  1   register-bus write request
//  reg_read         out  1   register-bus read request
//  reg_rdata        in   32  read data; valid in the cycle reg_read=1 and reg_waitrequest=0
//  reg_waitrequest  in   1   stall; the request and its addr/data are held while high
//  fifo_level       out  AW+1  current FIFO occupancy
//  overflow         out  1   sticky; set when a push is dropped
// BEHAVIOUR
//  Reset: all outputs 0 immediately; FIFO empty; response slot empty; scan index 0; FSM IDLE.
//  Reset during a bus transfer drops the request at once; the transfer is not resumed.
//  Push: wr & ~wr_q. When level==DEPTH the push is dropped and overflow<=1.
//  Push and pop in the same cycle: level unchanged.
//  wr_busy: registered, equals (level >= DEPTH-1). This leaves one slot for an in-flight push.
//  wr_instruction[31:16] is ignored.
//  FSM states: IDLE, WRITE, READ.
//   IDLE->WRITE when the FIFO is not empty. This has priority, even while a response is pending.
//     On this transition: pop the head; drive reg_addr=instr[15:0], reg_wdata=instr[63:32],
//     reg_write=1.
//   IDLE->READ when the FIFO is empty, scan_en=1 and the response slot is empty.
//     Drive reg_addr = SCAN_BASE+idx and reg_read=1.
//   WRITE->IDLE on the first cycle with reg_waitrequest=0; reg_write<=0.
//     Exactly one accepted write per command.
//   READ->IDLE on the first cycle with reg_waitrequest=0: capture reg_rdata into the slot,
//     rd_valid<=1, rd_instruction <= {reg_rdata, 16'h0, RD_ADDR_BASE+idx}.
//     idx increments and wraps SCAN_LEN-1 -> 0.
//  A new command may leave IDLE on the cycle after returning to IDLE (minimum 2 cycles per op).
//  Response slot: holds rd_valid and rd_instruction stable until the rising edge of rd.
//   On that edge: rd_valid<=0 next cycle; the slot is then empty.
//   rd while rd_valid=0 is ignored.
//  scan_en falling mid-READ: the read completes and its response is delivered.
//  Addition RD_ADDR_BASE+idx is 16-bit, no saturation.
// TESTING
//  1. wr high 2 cycles, instr=64'hDEADBEEF_0000_0064, waitrequest high 3 cycles
//     -> one reg_write, addr 0x0064, data DEADBEEF, held 4 cycles; fifo_level 1->0.
//  2. Waitrequest stuck high, 17 pushes -> wr_busy=1 once level reaches 15; level saturates at 16;
//     17th push dropped, overflow=1 and stays 1.
//  3. scan_en=1, reg_rdata=addr+0x1000 -> rd_instruction=64'h00001000_0000_012C;
//     rd held 2 cycles pops once; after 64 responses dest wraps back to 300.
//  4. Response pending (rd low), then push {0x55,0x0010} -> write executes at once;
//     rd_instruction unchanged; no new scan read until rd.
//  5. s_reset during reg_write with waitrequest high -> reg_write=0 immediately, level=0,
//     rd_valid=0, overflow=0.
//  6. Level 5, push and completed write-pop in same cycle -> level stays 5, order preserved.

Source files
------------

// File: rtl/hps_cmd_bridge.sv
// Bridges HPS terminal write instructions onto the GPIP register bus and, when idle,
// scans a register window back to the terminal as read instructions.
module hps_cmd_bridge #(
  parameter int          DEPTH        = 16,
  parameter int          AW           = 4,
  parameter logic [15:0] SCAN_BASE    = 16'h0000,
  parameter int          SCAN_LEN     = 64,
  parameter int          RD_ADDR_BASE = 300
) (
  input  logic          s_clk,
  input  logic          s_reset,
  input  logic          wr,
  input  logic [63:0]   wr_instruction,
  output logic          wr_busy,
  output logic          rd_valid,
  output logic [63:0]   rd_instruction,
  input  logic          rd,
  input  logic          scan_en,
  output logic [15:0]   reg_addr,
  output logic [31:0]   reg_wdata,
  output logic          reg_write,
  output logic          reg_read,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_waitrequest,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  localparam int IW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          wr_q;
  logic          rd_q;
  logic [IW-1:0] idx;
  logic          push_edge;
  logic          push_ok;
  logic          pop;
  logic [AW:0]   level_next;
  logic          unused_rsvd;

  // Only the data and address fields are stored; the reserved field is discarded.
  assign unused_rsvd = ^wr_instruction[31:16];
  assign push_edge   = wr & ~wr_q;
  assign push_ok     = push_edge && (fifo_level != (AW+1)'(DEPTH));
  assign pop         = (state == IDLE) && (fifo_level != '0);
  assign level_next  = fifo_level + (AW+1)'(push_ok) - (AW+1)'(pop);

  always_ff @(posedge s_clk) begin
    if (push_ok) begin
      mem[tail] <= {wr_instruction[63:32], wr_instruction[15:0]};
    end
  end

  // Pending commands always win over the background scan, even with a response held.
  always_ff @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      state          <= IDLE;
      head           <= '0;
      tail           <= '0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      idx            <= '0;
      fifo_level     <= '0;
      wr_busy        <= 1'b0;
      overflow       <= 1'b0;
      rd_valid       <= 1'b0;
      rd_instruction <= '0;
      reg_addr       <= '0;
      reg_wdata      <= '0;
      reg_write      <= 1'b0;
      reg_read       <= 1'b0;
    end else begin
      wr_q       <= wr;
      rd_q       <= rd;
      fifo_level <= level_next;
      wr_busy    <= (level_next >= (AW+1)'(DEPTH - 1));
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (push_edge && !push_ok) begin
        overflow <= 1'b1;
      end
      if (rd && !rd_q && rd_valid) begin
        rd_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            reg_addr  <= mem[head][15:0];
            reg_wdata <= mem[head][47:16];
            reg_write <= 1'b1;
            head      <= head + 1'b1;
            state     <= WRITE;
          end else if (scan_en && !rd_valid) begin
            reg_addr <= SCAN_BASE + 16'(idx);
            reg_read <= 1'b1;
            state    <= READ;
          end
        end
        WRITE: begin
          if (!reg_waitrequest) begin
            reg_write <= 1'b0;
            state     <= IDLE;
          end
        end
        READ: begin
          if (!reg_waitrequest) begin
            reg_read       <= 1'b0;
            rd_valid       <= 1'b1;
            rd_instruction <= {reg_rdata, 16'h0000, 16'(RD_ADDR_BASE) + 16'(idx)};
            idx            <= (idx == IW'(SCAN_LEN - 1)) ? '0 : idx + 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Self-checking bench for hps_cmd_bridge: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hps_cmd_bridge;

  logic        s_clk = 1'b0;
  logic        s_reset;
  logic        wr;
  logic [63:0] wr_instruction;
  logic        wr_busy;
  logic        rd_valid;
  logic [63:0] rd_instruction;
  logic        rd;
  logic        scan_en;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_rdata;
  logic        reg_waitrequest;
  logic [4:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int write_high = 0;
  int accepted_writes = 0;
  logic [15:0] last_wr_addr = '0;

  hps_cmd_bridge dut (
    .s_clk(s_clk), .s_reset(s_reset), .wr(wr), .wr_instruction(wr_instruction),
    .wr_busy(wr_busy), .rd_valid(rd_valid), .rd_instruction(rd_instruction), .rd(rd),
    .scan_en(scan_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata), .reg_waitrequest(reg_waitrequest),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 s_clk = ~s_clk;

  // Register-bus slave: every scanned register reads back as its address plus 0x1000.
  assign reg_rdata = {16'h0000, reg_addr} + 32'h0000_1000;

  logic [47:0] m_q[$];
  int          m_op;
  logic [47:0] m_cur;
  logic [15:0] m_raddr;
  bit          m_ovf;
  bit          m_slot;
  logic [63:0] m_slot_data;
  int          m_idx;
  bit          m_wr_prev;
  bit          m_rd_prev;
  bit          m_push;
  bit          m_slot_pre;
  int          m_pre_level;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] instr);
    wr_instruction = instr;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic waitUntil(input int sel, input string name);
    for (int n = 0; n < 300; n++) begin
      if ((sel == 0 && reg_write) || (sel == 1 && rd_valid) ||
          (sel == 2 && fifo_level == 0 && !reg_write && !reg_read)) return;
      tick();
    end
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s: condition never seen, required within 300 cycles", name);
  endtask

  // Reference model: op 0 idle, 1 writing, 2 reading; operates on pre-edge values.
  always @(posedge s_clk or posedge s_reset) begin
    if (s_reset) begin
      m_q.delete();
      m_op = 0; m_cur = '0; m_raddr = '0; m_ovf = 0; m_slot = 0; m_slot_data = '0;
      m_idx = 0; m_wr_prev = 0; m_rd_prev = 0;
    end else begin
      m_pre_level = m_q.size();
      m_slot_pre  = m_slot;
      m_push      = wr && !m_wr_prev;
      if (rd && !m_rd_prev && m_slot_pre) m_slot = 0;
      case (m_op)
        0: begin
          if (m_pre_level > 0) begin
            m_cur = m_q.pop_front();
            m_op  = 1;
          end else if (scan_en && !m_slot_pre) begin
            m_raddr = 16'h0000 + 16'(m_idx);
            m_op    = 2;
          end
        end
        1: if (!reg_waitrequest) m_op = 0;
        default: begin
          if (!reg_waitrequest) begin
            m_slot      = 1;
            m_slot_data = {32'(m_raddr) + 32'h1000, 16'h0000, 16'(300 + m_idx)};
            m_idx       = (m_idx + 1) % 64;
            m_op        = 0;
          end
        end
      endcase
      if (m_push) begin
        if (m_pre_level == 16) m_ovf = 1;
        else m_q.push_back({wr_instruction[63:32], wr_instruction[15:0]});
      end
      m_wr_prev = wr;
      m_rd_prev = rd;
    end
  end

  always @(negedge s_clk) begin
    if (!s_reset) begin
      checkOutput("reg_write", 64'(reg_write), 64'(m_op == 1));
      checkOutput("reg_read", 64'(reg_read), 64'(m_op == 2));
      if (m_op == 1) begin
        checkOutput("write_addr", 64'(reg_addr), 64'(m_cur[15:0]));
        checkOutput("write_data", 64'(reg_wdata), 64'(m_cur[47:16]));
      end
      if (m_op == 2) checkOutput("read_addr", 64'(reg_addr), 64'(m_raddr));
      checkOutput("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      checkOutput("wr_busy", 64'(wr_busy), 64'(m_q.size() >= 15));
      checkOutput("overflow", 64'(overflow), 64'(m_ovf));
      checkOutput("rd_valid", 64'(rd_valid), 64'(m_slot));
      if (m_slot) checkOutput("rd_instruction", rd_instruction, m_slot_data);
      if (reg_write) write_high++;
      if (reg_write && !reg_waitrequest) begin
        accepted_writes++;
        last_wr_addr = reg_addr;
      end
    end
  end

  initial begin
    s_reset = 1'b1; wr = 1'b0; rd = 1'b0; scan_en = 1'b0;
    reg_waitrequest = 1'b1; wr_instruction = '0;
    tick();
    tick();
    checkOutput("reset_reg_write", 64'(reg_write), 64'd0);
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("reset_rd_instruction", rd_instruction, 64'd0);
    checkOutput("reset_fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("reset_wr_busy", 64'(wr_busy), 64'd0);
    s_reset = 1'b0;
    tick();

    // Scenario 1: wr held two cycles, write stalled three cycles.
    write_high = 0;
    accepted_writes = 0;
    wr_instruction = 64'hDEADBEEF_0000_0064;
    wr = 1'b1;
    tick();
    checkOutput("t1_level_after_push", 64'(fifo_level), 64'd1);
    tick();
    checkOutput("t1_reg_write", 64'(reg_write), 64'd1);
    checkOutput("t1_reg_addr", 64'(reg_addr), 64'h0064);
    checkOutput("t1_reg_wdata", 64'(reg_wdata), 64'hDEADBEEF);
    checkOutput("t1_level_after_pop", 64'(fifo_level), 64'd0);
    wr = 1'b0;
    repeat (3) tick();
    reg_waitrequest = 1'b0;
    tick();
    tick();
    checkOutput("t1_write_cycles", 64'(write_high), 64'd4);
    checkOutput("t1_accepted_writes", 64'(accepted_writes), 64'd1);

    // Scenario 2: stuck bus, one command in flight plus seventeen more pushes.
    reg_waitrequest = 1'b1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus({32'hA000_0000 + 32'(i), 16'hFFFF, 16'(i)});
      if (i == 14) begin
        checkOutput("t2_level_14", 64'(fifo_level), 64'd14);
        checkOutput("t2_busy_at_14", 64'(wr_busy), 64'd0);
      end
      if (i == 15) begin
        checkOutput("t2_level_15", 64'(fifo_level), 64'd15);
        checkOutput("t2_busy_at_15", 64'(wr_busy), 64'd1);
      end
    end
    checkOutput("t2_level_full", 64'(fifo_level), 64'd16);
    checkOutput("t2_overflow", 64'(overflow), 64'd1);
    reg_waitrequest = 1'b0;
    waitUntil(2, "t2_drain");
    checkOutput("t2_overflow_sticky", 64'(overflow), 64'd1);
    checkOutput("t2_last_addr", 64'(last_wr_addr), 64'h0010);

    // Scenario 3: background scan and readback index wrap.
    scan_en = 1'b1;
    waitUntil(1, "t3_first_response");
    checkOutput("t3_first_response", rd_instruction, 64'h00001000_0000_012C);
    rd = 1'b1;
    repeat (4) tick();
    rd = 1'b0;
    tick();
    checkOutput("t3_held_rd_single_pop", 64'(rd_valid), 64'd1);
    checkOutput("t3_second_response", rd_instruction, 64'h00001001_0000_012D);
    for (int k = 1; k <= 64; k++) begin
      waitUntil(1, "t3_response");
      if (k == 63) checkOutput("t3_response_63", rd_instruction, 64'h0000103F_0000_016B);
      if (k == 64) begin
        checkOutput("t3_wrapped_response", rd_instruction, 64'h00001000_0000_012C);
        break;
      end
      rd = 1'b1;
      tick();
      rd = 1'b0;
      tick();
    end

    // Scenario 4: command overtakes a held response; scan waits for rd.
    applyStimulus(64'h00000055_0000_0010);
    checkOutput("t4_reg_write", 64'(reg_write), 64'd1);
    checkOutput("t4_reg_addr", 64'(reg_addr), 64'h0010);
    checkOutput("t4_reg_wdata", 64'(reg_wdata), 64'h55);
    repeat (6) tick();
    checkOutput("t4_no_scan_read", 64'(reg_read), 64'd0);
    checkOutput("t4_response_held", rd_instruction, 64'h00001000_0000_012C);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    waitUntil(1, "t4_next_response");
    checkOutput("t4_next_response", rd_instruction, 64'h00001001_0000_012D);

    // Scenario 5: asynchronous reset in the middle of a stalled write.
    reg_waitrequest = 1'b1;
    applyStimulus(64'h11111111_0000_0020);
    checkOutput("t5_write_active", 64'(reg_write), 64'd1);
    applyStimulus(64'h22222222_0000_0021);
    @(posedge s_clk);
    #3;
    s_reset = 1'b1;
    #1;
    checkOutput("t5_reg_write_cleared", 64'(reg_write), 64'd0);
    checkOutput("t5_level_cleared", 64'(fifo_level), 64'd0);
    checkOutput("t5_rd_valid_cleared", 64'(rd_valid), 64'd0);
    checkOutput("t5_overflow_cleared", 64'(overflow), 64'd0);
    scan_en = 1'b0;
    reg_waitrequest = 1'b0;
    tick();
    s_reset = 1'b0;
    repeat (3) tick();
    checkOutput("t5_not_resumed", 64'(reg_write), 64'd0);

    // Scenario 6: simultaneous push and pop at level 5.
    reg_waitrequest = 1'b1;
    accepted_writes = 0;
    for (int i = 0; i < 6; i++) applyStimulus({32'hC000_0000 + 32'(i), 16'h0000, 16'h0100 + 16'(i)});
    checkOutput("t6_level_5", 64'(fifo_level), 64'd5);
    reg_waitrequest = 1'b0;
    tick();
    wr_instruction = 64'hC0000006_0000_0106;
    wr = 1'b1;
    tick();
    checkOutput("t6_level_push_pop", 64'(fifo_level), 64'd5);
    reg_waitrequest = 1'b1;
    wr = 1'b0;
    tick();
    checkOutput("t6_level_stable", 64'(fifo_level), 64'd5);
    checkOutput("t6_order_head", 64'(reg_addr), 64'h0101);
    reg_waitrequest = 1'b0;
    waitUntil(2, "t6_drain");
    tick();
    checkOutput("t6_accepted_writes", 64'(accepted_writes), 64'd7);
    checkOutput("t6_last_addr", 64'(last_wr_addr), 64'h0106);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
